// File: rtl/sabertooth_serial_decoder_pkg.sv
// Shared uniboard definitions for the Sabertooth simplified-serial link.
//   rx_state_t        : receiver FSM states (IDLE/START/DATA/STOP)
//   MOTOR_STOP        : motor value meaning "stopped" on the 0..255 scale
//   CLKS_PER_BIT_9600 : 12 MHz clock cycles per bit at 9600 baud
//   motor_level()     : 7-bit command magnitude -> 8-bit motor value
package sabertooth_serial_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] MOTOR_STOP = 8'd127;

  localparam int unsigned CLK_HZ            = 12_000_000;
  localparam int unsigned BAUD              = 9600;
  localparam int unsigned CLKS_PER_BIT_9600 = CLK_HZ / BAUD;

  // Magnitude 1..127 maps to 1..253 in steps of two; magnitude 0 (command
  // byte 128) clamps to 1 instead of wrapping to full scale.
  function automatic logic [7:0] motor_level(input logic [6:0] mag);
    return (mag == 7'd0) ? 8'd1 : {mag - 7'd1, 1'b1};
  endfunction

endpackage

// File: rtl/sabertooth_serial_decoder_uart_rx_byte.sv
// 8N1 byte receiver.
//   clk_12MHz  : sole clock
//   reset      : asynchronous, active-low
//   rx         : serial line, idle high, asynchronous to clk_12MHz
//   data       : last accepted byte (valid with byte_valid)
//   byte_valid : one-cycle pulse, byte received with a good stop bit
//   frame_err  : one-cycle pulse, stop bit sampled low (byte discarded)
module uart_rx_byte
  import sabertooth_serial_decoder_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_9600
) (
  input  logic       clk_12MHz,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta;
  logic            rx_sync;
  rx_state_t       state;
  logic            armed;     // line has been seen high since reset / last framing error
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  // Two-flop synchronizer, reset to the idle level so reset never looks like a start bit.
  // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_12MHz or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // NOTE: the data path (shift, data) is reset along with the control state so no X leaks out after reset.
  always_ff @(posedge clk_12MHz or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      armed      <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (rx_sync)    armed <= 1'b1;
          else if (armed) state <= START;
        end
        START: begin
          // Re-check at mid start bit; a high line here means the edge was a glitch.
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            state    <= rx_sync ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            shift    <= {rx_sync, shift[7:1]};  // LSB arrives first
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
            if (rx_sync) begin
              data       <= shift;
              byte_valid <= 1'b1;
            end else begin
              // Line may still be low (break); wait for it to go high before re-arming.
              frame_err <= 1'b1;
              armed     <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sabertooth_serial_decoder.sv
// Sabertooth simplified-serial receiver: decodes each accepted byte into
// motor 1 (1..127) or motor 2 (128..255), 0 stops both; line silence for
// TIMEOUT_CYCLES forces both motors to stop.
//   clk_12MHz   : sole clock
//   reset       : asynchronous, active-low
//   rx          : serial line, idle high
//   m1, m2      : motor values, 127 = stop
//   m1_update   : one-cycle pulse when m1 is written by a byte
//   m2_update   : one-cycle pulse when m2 is written by a byte
//   frame_error : one-cycle pulse on a bad stop bit
//   timed_out   : high while the failsafe holds the motors stopped
module sabertooth_serial_decoder
  import sabertooth_serial_decoder_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = CLKS_PER_BIT_9600,
  parameter int unsigned TIMEOUT_CYCLES = 1_200_000
) (
  input  logic       clk_12MHz,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] m1,
  output logic [7:0] m2,
  output logic       m1_update,
  output logic       m2_update,
  output logic       frame_error,
  output logic       timed_out
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_SAT = TW'(TIMEOUT_CYCLES);

  logic [7:0]    data;
  logic          byte_valid;
  logic [TW-1:0] to_cnt;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk_12MHz  (clk_12MHz),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .byte_valid (byte_valid),
    .frame_err  (frame_error)
  );

  // Counter starts saturated so the failsafe is active out of reset.
  always_ff @(posedge clk_12MHz or negedge reset) begin
    if (!reset) begin
      m1        <= MOTOR_STOP;
      m2        <= MOTOR_STOP;
      m1_update <= 1'b0;
      m2_update <= 1'b0;
      timed_out <= 1'b1;
      to_cnt    <= TO_SAT;
    end else begin
      m1_update <= 1'b0;
      m2_update <= 1'b0;
      if (byte_valid) begin
        // An accepted byte takes priority over a timeout landing in the same cycle.
        to_cnt    <= '0;
        timed_out <= 1'b0;
        if (data == 8'd0) begin
          m1        <= MOTOR_STOP;
          m2        <= MOTOR_STOP;
          m1_update <= 1'b1;
          m2_update <= 1'b1;
        end else if (!data[7]) begin
          m1        <= motor_level(data[6:0]);
          m1_update <= 1'b1;
        end else begin
          m2        <= motor_level(data[6:0]);
          m2_update <= 1'b1;
        end
      end else if (TIMEOUT_CYCLES != 0) begin
        if (to_cnt == TO_SAT) begin
          timed_out <= 1'b1;
          m1        <= MOTOR_STOP;
          m2        <= MOTOR_STOP;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sabertooth_serial_decoder.sv
`timescale 1ns/1ps
module tb_sabertooth_serial_decoder;

  localparam int CPB = 200;
  localparam int TO  = 5000;

  logic       clk_12MHz = 1'b0;
  logic       reset     = 1'b0;
  logic       rx        = 1'b1;
  logic [7:0] m1, m2;
  logic       m1_update, m2_update, frame_error, timed_out;

  int checks = 0;
  int errors = 0;
  int n_m1 = 0, n_m2 = 0, n_fe = 0;

  // Reference model state
  logic [7:0] exp_m1 = 8'd127;
  logic [7:0] exp_m2 = 8'd127;
  logic       exp_to = 1'b1;

  sabertooth_serial_decoder #(
    .CLKS_PER_BIT   (CPB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_12MHz   (clk_12MHz),
    .reset       (reset),
    .rx          (rx),
    .m1          (m1),
    .m2          (m2),
    .m1_update   (m1_update),
    .m2_update   (m2_update),
    .frame_error (frame_error),
    .timed_out   (timed_out)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  // Pulse counters, plus: any update pulse must coincide with timed_out low.
  always @(negedge clk_12MHz) begin
    if (m1_update)   n_m1++;
    if (m2_update)   n_m2++;
    if (frame_error) n_fe++;
    if (m1_update || m2_update) begin
      checks++;
      if (timed_out !== 1'b0) begin
        errors++;
        $display("FAIL update_clears_timeout timed_out=%b required 0", timed_out);
      end
    end
  end

  // Model: command byte -> motor values from the documented scale.
  function automatic void model_byte(input int b);
    if (b == 0) begin
      exp_m1 = 8'd127;
      exp_m2 = 8'd127;
    end else if (b < 128) begin
      exp_m1 = 8'(2 * b - 1);
    end else begin
      exp_m2 = (b == 128) ? 8'd1 : 8'(2 * (b - 128) - 1);
    end
    exp_to = 1'b0;
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk_12MHz);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (CPB) @(negedge clk_12MHz);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk_12MHz);
    end
    rx = stop_ok;
    repeat (CPB) @(negedge clk_12MHz);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk_12MHz);
    checks++;
    if ({m1, m2, m1_update, m2_update, frame_error, timed_out} !== {8'd127, 8'd127, 4'b0001}) begin
      errors++;
      $display("FAIL reset_hold m1=%0d m2=%0d pulses=%b%b%b to=%b required 127 127 000 1",
               m1, m2, m1_update, m2_update, frame_error, timed_out);
    end
    reset = 1'b1;
    idle(50);
    checks++;
    if ({m1, m2, timed_out} !== {exp_m1, exp_m2, exp_to} || (n_m1 + n_m2 + n_fe) != 0) begin
      errors++;
      $display("FAIL reset_release m1=%0d m2=%0d to=%b pulses=%0d required 127 127 1 0",
               m1, m2, timed_out, n_m1 + n_m2 + n_fe);
    end
  endtask

  task automatic test_single_bytes();
    logic [7:0] seq [2] = '{8'h40, 8'hC0};
    for (int i = 0; i < 2; i++) begin
      int s1 = n_m1, s2 = n_m2;
      send_frame(seq[i], 1'b1);
      model_byte(int'(seq[i]));
      checks++;
      if ({m1, m2, timed_out} !== {exp_m1, exp_m2, exp_to}) begin
        errors++;
        $display("FAIL single_%02h m1=%0d m2=%0d to=%b required %0d %0d %b",
                 seq[i], m1, m2, timed_out, exp_m1, exp_m2, exp_to);
      end
      checks++;
      if ((n_m1 - s1) != (i == 0 ? 1 : 0) || (n_m2 - s2) != (i == 1 ? 1 : 0)) begin
        errors++;
        $display("FAIL single_%02h_pulses m1_upd=%0d m2_upd=%0d required %0d %0d",
                 seq[i], n_m1 - s1, n_m2 - s2, (i == 0 ? 1 : 0), (i == 1 ? 1 : 0));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [4] = '{8'h01, 8'h7F, 8'h80, 8'hFF};
    int s1 = n_m1, s2 = n_m2;
    for (int i = 0; i < 4; i++) begin
      send_frame(seq[i], 1'b1);  // next start bit follows immediately
      model_byte(int'(seq[i]));
      checks++;
      if ({m1, m2} !== {exp_m1, exp_m2}) begin
        errors++;
        $display("FAIL b2b_%02h m1=%0d m2=%0d required %0d %0d", seq[i], m1, m2, exp_m1, exp_m2);
      end
    end
    idle(20);
    checks++;
    if ((n_m1 - s1) != 2 || (n_m2 - s2) != 2) begin
      errors++;
      $display("FAIL b2b_pulses m1_upd=%0d m2_upd=%0d required 2 2", n_m1 - s1, n_m2 - s2);
    end
  endtask

  task automatic test_frame_error();
    int s1 = n_m1, s2 = n_m2, sf = n_fe;
    send_frame(8'h55, 1'b0);
    idle(CPB);
    checks++;
    if ((n_fe - sf) != 1 || n_m1 != s1 || n_m2 != s2) begin
      errors++;
      $display("FAIL frame_error fe=%0d upd=%0d required fe=1 upd=0", n_fe - sf, (n_m1 - s1) + (n_m2 - s2));
    end
    checks++;
    if ({m1, m2, timed_out} !== {exp_m1, exp_m2, exp_to}) begin
      errors++;
      $display("FAIL frame_error_hold m1=%0d m2=%0d to=%b required %0d %0d %b",
               m1, m2, timed_out, exp_m1, exp_m2, exp_to);
    end
    // Low pulse shorter than half a bit must be rejected.
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk_12MHz);
    idle(3 * CPB);
    checks++;
    if ((n_fe - sf) != 1 || n_m1 != s1 || n_m2 != s2 || {m1, m2} !== {exp_m1, exp_m2}) begin
      errors++;
      $display("FAIL glitch fe=%0d upd=%0d m1=%0d m2=%0d required fe=1 upd=0 %0d %0d",
               n_fe - sf, (n_m1 - s1) + (n_m2 - s2), m1, m2, exp_m1, exp_m2);
    end
  endtask

  task automatic test_timeout();
    int s1, s2;
    send_frame(8'h7F, 1'b1);
    model_byte(8'h7F);
    checks++;
    if (m1 !== 8'd253) begin
      errors++;
      $display("FAIL timeout_setup m1=%0d required 253", m1);
    end
    s1 = n_m1;
    s2 = n_m2;
    idle(TO - 200);  // just short of the failsafe
    checks++;
    if ({m1, timed_out} !== {exp_m1, 1'b0}) begin
      errors++;
      $display("FAIL timeout_early m1=%0d to=%b required %0d 0", m1, timed_out, exp_m1);
    end
    idle(400);
    exp_m1 = 8'd127;
    exp_m2 = 8'd127;
    exp_to = 1'b1;
    checks++;
    if ({m1, m2, timed_out} !== {exp_m1, exp_m2, exp_to} || n_m1 != s1 || n_m2 != s2) begin
      errors++;
      $display("FAIL timeout_fire m1=%0d m2=%0d to=%b upd=%0d required 127 127 1 0",
               m1, m2, timed_out, (n_m1 - s1) + (n_m2 - s2));
    end
    send_frame(8'h00, 1'b1);
    model_byte(0);
    checks++;
    if ({m1, m2, timed_out} !== {exp_m1, exp_m2, exp_to} || (n_m1 - s1) != 1 || (n_m2 - s2) != 1) begin
      errors++;
      $display("FAIL timeout_recover m1=%0d m2=%0d to=%b upd=%0d/%0d required 127 127 0 1/1",
               m1, m2, timed_out, n_m1 - s1, n_m2 - s2);
    end
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] b = 8'h7F;
    int s1, s2, sf;
    idle(20);
    s1 = n_m1;
    s2 = n_m2;
    sf = n_fe;
    rx = 1'b0;
    repeat (CPB) @(negedge clk_12MHz);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == 4) begin
        repeat (CPB / 2) @(negedge clk_12MHz);
        reset = 1'b0;
        @(negedge clk_12MHz);
        checks++;
        if ({m1, m2, m1_update, m2_update, frame_error, timed_out} !== {8'd127, 8'd127, 4'b0001}) begin
          errors++;
          $display("FAIL reset_mid m1=%0d m2=%0d to=%b required 127 127 1", m1, m2, timed_out);
        end
        repeat (CPB / 2 - 1) @(negedge clk_12MHz);
      end else begin
        repeat (CPB) @(negedge clk_12MHz);
      end
    end
    rx = 1'b1;  // stop bit; release reset partway through
    repeat (CPB / 2) @(negedge clk_12MHz);
    reset = 1'b1;
    exp_m1 = 8'd127;
    exp_m2 = 8'd127;
    exp_to = 1'b1;
    idle(CPB / 2 + 2 * CPB);
    checks++;
    if ({m1, m2, timed_out} !== {exp_m1, exp_m2, exp_to} || n_m1 != s1 || n_m2 != s2 || n_fe != sf) begin
      errors++;
      $display("FAIL reset_mid_after m1=%0d m2=%0d to=%b pulses=%0d required 127 127 1 0",
               m1, m2, timed_out, (n_m1 - s1) + (n_m2 - s2) + (n_fe - sf));
    end
    send_frame(8'h60, 1'b1);
    model_byte(8'h60);
    checks++;
    if ({m1, m2, timed_out} !== {8'd191, exp_m2, exp_to} || m1 !== exp_m1) begin
      errors++;
      $display("FAIL reset_mid_next m1=%0d m2=%0d to=%b required 191 %0d %b",
               m1, m2, timed_out, exp_m2, exp_to);
    end
  endtask

  task automatic test_random();
    bit prev_bad = 1'b0;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b = 8'($urandom_range(0, 255));
      bit ok = prev_bad || ($urandom_range(0, 9) != 0);
      int s1 = n_m1, s2 = n_m2, sf = n_fe;
      int d1 = (ok && b != 0 && b < 128) || (ok && b == 0) ? 1 : 0;
      int d2 = (ok && b >= 128) || (ok && b == 0) ? 1 : 0;
      send_frame(b, ok);
      if (ok) model_byte(int'(b));
      checks++;
      if ({m1, m2, timed_out} !== {exp_m1, exp_m2, exp_to}) begin
        errors++;
        $display("FAIL rand_%0d_%02h m1=%0d m2=%0d to=%b required %0d %0d %b",
                 n, b, m1, m2, timed_out, exp_m1, exp_m2, exp_to);
      end
      checks++;
      if ((n_m1 - s1) != d1 || (n_m2 - s2) != d2 || (n_fe - sf) != (ok ? 0 : 1)) begin
        errors++;
        $display("FAIL rand_%0d_%02h_pulses upd=%0d/%0d fe=%0d required %0d/%0d %0d",
                 n, b, n_m1 - s1, n_m2 - s2, n_fe - sf, d1, d2, (ok ? 0 : 1));
      end
      prev_bad = !ok;
      idle(ok ? $urandom_range(0, 30) : $urandom_range(20, 60));
    end
  endtask

  initial begin
    test_reset();
    test_single_bytes();
    test_back_to_back();
    test_frame_error();
    test_timeout();
    test_reset_mid_byte();
    test_random();
    idle(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sabertooth_serial_decoder.md
# sabertooth_serial_decoder

Receive-side counterpart to the Sabertooth simplified-serial motor output: samples an 8N1 serial line at 9600 baud, decodes each byte into the two motor channels, and presents them as 8-bit speed values. Motor values use the same 0 = full reverse, 127 = stop, 255 = full forward scale the rest of the uniboard uses. It serves as the loopback checker for the motor serial output and as the front end of the bench Sabertooth emulator. A line-silence failsafe forces both channels to stop.

## Interface
- CLKS_PER_BIT, 1250, clk_12MHz cycles per bit (9600 baud at 12 MHz).
- TIMEOUT_CYCLES, 1200000, cycles with no accepted byte before failsafe (100 ms); 0 disables the timeout.
- clk_12MHz  input  1  sole clock.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high; asynchronous to the clock.
- m1  output  8  decoded motor 1 value; reset 127.
- m2  output  8  decoded motor 2 value; reset 127.
- m1_update  output  1  one-cycle pulse when m1 is written; reset 0.
- m2_update  output  1  one-cycle pulse when m2 is written; reset 0.
- frame_error  output  1  one-cycle pulse when a byte has a bad stop bit; reset 0.
- timed_out  output  1  level, high while the failsafe is active; reset 1.

## Operation
- rx passes through a 2-flop synchronizer, reset to 1. All decoding uses the synchronized copy.
- Receiver FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronized low.
  - START waits CLKS_PER_BIT/2 cycles (625), then re-samples the line. If the line is high, the edge was a glitch: return to IDLE with no output. If low, go to DATA.
  - DATA samples 8 bits, LSB first, every CLKS_PER_BIT cycles.
  - STOP samples once after a further CLKS_PER_BIT cycles.
    - Sample 1: byte accepted, go to IDLE.
    - Sample 0: pulse frame_error, discard the byte, go to IDLE. A new start bit is only detected after rx returns high.
- Byte decode, applied only to accepted bytes:
  - b = 0: m1 = m2 = 127; pulse both m1_update and m2_update.
  - b = 1..127: m1 = {b[6:0] - 1, 1'b1}. 1 -> 1, 64 -> 127, 127 -> 253. Pulse m1_update.
  - b = 128: m2 = 1 (explicit clamp, no wrap). Pulse m2_update.
  - b = 129..255: m2 = {b[6:0] - 1, 1'b1}. 192 -> 127, 255 -> 253. Pulse m2_update.
- Failsafe:
  - A timeout counter clears on every accepted byte and saturates at TIMEOUT_CYCLES.
  - At saturation: timed_out = 1, m1 = m2 = 127, no update pulses.
  - The next accepted byte clears timed_out in the same cycle it updates its channel. The other channel stays at 127 until written.
- Framing errors and glitches do not clear the timeout counter.

## Timing
- The synchronizer adds 2 cycles. The start edge is recognised 2–3 cycles after the rx fall.
- Update pulses and the new m1/m2 value appear on the cycle after the stop-bit sample. That is about 9.5 bit times (11875 cycles ± 3) after the start-bit fall. m1/m2 are registered and hold until the next update.
- Back-to-back bytes with a 1-bit stop and no idle gap must be received. The FSM is back in IDLE half a bit before the next start edge.
- Reset mid-byte: all state returns to reset values immediately. The partial byte is lost. After release the FSM sits in IDLE and waits for rx to be high before accepting a start edge.
- A timeout that saturates in the same cycle as a byte accept: the accept wins. The counter clears and timed_out stays 0.
- Tolerates ±2 % baud mismatch, since the mid-bit sample lands inside the bit for all 10 bits.

## Structure
- Shared uniboard package holds:
  - FSM state enum (IDLE/START/DATA/STOP);
  - MOTOR_STOP = 8'd127;
  - the 12 MHz / 9600 CLKS_PER_BIT constant used by both the transmit and receive sides.
- Sub-module uart_rx_byte contains the synchronizer, FSM, bit counter and baud counter. It outputs data[7:0], a byte_valid pulse and a frame_err pulse.
- The top level holds the decode, the m1/m2 registers and the timeout counter.

## Test plan
- Reset release with rx idle high -> m1 = m2 = 127, timed_out = 1, no pulses.
- Send 0x40 then 0xC0 -> m1 = 127 with m1_update; then m2 = 127 with m2_update; timed_out = 0 after the first byte.
- Send 0x01, 0x7F, 0x80, 0xFF back-to-back with no gap -> m1 = 1, then m1 = 253, then m2 = 1, then m2 = 253; exactly four update pulses.
- Drive a byte whose stop bit is 0 -> frame_error pulses once, m1/m2 unchanged. Also drive a 300-cycle low glitch -> no output at all.
- Set m1 = 253 via 0x7F, then leave the line idle for TIMEOUT_CYCLES (use 5000 in the bench) -> timed_out = 1, m1 = 127. Then send 0x00 -> timed_out = 0 and both update pulses.
- Assert reset during the 4th data bit of 0x7F, then release -> outputs at reset values, no update. A following 0x60 decodes to m1 = 191.
